ps2_keycode_rx: RTL

//   Keyboard front end that produces the 8-bit keycode consumed by the frog movement logic.

---
 rtl/frogger_kb_pkg.sv | 61 ++++++
 rtl/ps2_frame_rx.sv | 108 ++++++++++
 rtl/ps2_keycode_rx.sv | 100 ++++++++++
 3 files changed

// File: rtl/frogger_kb_pkg.sv
// rtl/frogger_kb_pkg.sv - HID/scan-code constants, decoder state type and key maps
// Build macro: PS2_WASD_EN adds W/A/S/D (1D/1C/1B/23) to the plain (non-E0) map.
package frogger_kb_pkg;

   localparam logic [7:0] KC_NONE  = 8'h00;
   localparam logic [7:0] KC_LEFT  = 8'h50;
   localparam logic [7:0] KC_UP    = 8'h52;
   localparam logic [7:0] KC_RIGHT = 8'h4F;
   localparam logic [7:0] KC_DOWN  = 8'h51;

   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BRK   = 8'hF0;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_W     = 8'h1D;
   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_S     = 8'h1B;
   localparam logic [7:0] SC_D     = 8'h23;

`ifdef PS2_WASD_EN
   localparam bit WASD_EN = 1'b1;
`else
   localparam bit WASD_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK
   } kb_state_t;

   // E0-prefixed arrow codes; KC_NONE means "not a movement key".
   function automatic logic [7:0] map_ext(input logic [7:0] sc);
      logic [7:0] kc;
      case (sc)
         SC_LEFT:  kc = KC_LEFT;
         SC_UP:    kc = KC_UP;
         SC_RIGHT: kc = KC_RIGHT;
         SC_DOWN:  kc = KC_DOWN;
         default:  kc = KC_NONE;
      endcase
      return kc;
   endfunction

   // Plain codes; empty unless the WASD option is built in.
   function automatic logic [7:0] map_plain(input logic [7:0] sc);
      logic [7:0] kc;
      case (sc)
         SC_W:    kc = WASD_EN ? KC_UP    : KC_NONE;
         SC_A:    kc = WASD_EN ? KC_LEFT  : KC_NONE;
         SC_S:    kc = WASD_EN ? KC_DOWN  : KC_NONE;
         SC_D:    kc = WASD_EN ? KC_RIGHT : KC_NONE;
         default: kc = KC_NONE;
      endcase
      return kc;
   endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 pin synchroniser, 11-bit frame shifter, frame checks and timeout
// Ports: Clk, Reset (sync, active-high); ps2_clk/ps2_data raw pins;
//        rx_byte[7:0] last accepted byte, byte_valid 1-cycle pulse, err 1-cycle reject/timeout pulse.
module ps2_frame_rx #(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
   logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
   logic                   clk_prev_q, clk_prev_d;
   logic [3:0]             bit_cnt_q, bit_cnt_d;
   logic [9:0]             shift_q, shift_d;
   logic [TW-1:0]          to_cnt_q, to_cnt_d;
   logic [7:0]             byte_q, byte_d;
   logic                   byte_valid_q, byte_valid_d;
   logic                   err_q, err_d;

   logic                   clk_s, data_s, fall;
   logic [10:0]            frame;
   logic                   frame_ok;

   assign clk_s  = clk_sync_q[SYNC_STAGES-1];
   assign data_s = data_sync_q[SYNC_STAGES-1];
   assign fall   = clk_prev_q & ~clk_s;

   // Complete frame as it stands on the 11th edge: [0]=start .. [10]=stop.
   assign frame    = {data_s, shift_q};
   assign frame_ok = ~frame[0] & (^frame[9:1]) & frame[10];

   always_comb begin
      clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_d  = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_d   = clk_s;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      to_cnt_d     = to_cnt_q;
      byte_d       = byte_q;
      byte_valid_d = 1'b0;
      err_d        = 1'b0;

      // An edge takes priority over a timeout expiring in the same cycle.
      if (fall) begin
         to_cnt_d = '0;
         if (bit_cnt_q == 4'd10) begin
            bit_cnt_d = 4'd0;
            if (frame_ok) begin
               byte_d       = frame[8:1];
               byte_valid_d = 1'b1;
            end else begin
               err_d = 1'b1;
            end
         end else begin
            shift_d   = {data_s, shift_q[9:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
         end
      end else if (bit_cnt_q != 4'd0) begin
         if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            to_cnt_d  = '0;
            bit_cnt_d = 4'd0;
            err_d     = 1'b1;
         end else begin
            to_cnt_d = to_cnt_q + TW'(1);
         end
      end else begin
         to_cnt_d = '0;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         clk_sync_q   <= '1;
         data_sync_q  <= '1;
         clk_prev_q   <= 1'b1;
         bit_cnt_q    <= 4'd0;
         shift_q      <= '0;
         to_cnt_q     <= '0;
         byte_q       <= 8'h00;
         byte_valid_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         clk_sync_q   <= clk_sync_d;
         data_sync_q  <= data_sync_d;
         clk_prev_q   <= clk_prev_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         to_cnt_q     <= to_cnt_d;
         byte_q       <= byte_d;
         byte_valid_q <= byte_valid_d;
         err_q        <= err_d;
      end
   end

   assign rx_byte    = byte_q;
   assign byte_valid = byte_valid_q;
   assign err        = err_q;

endmodule

// File: rtl/ps2_keycode_rx.sv
// rtl/ps2_keycode_rx.sv - PS/2 Set-2 make/break/E0 decoder producing a held HID arrow keycode
// Ports: Clk, Reset (sync, active-high); ps2_clk/ps2_data raw pins;
//        keycode[7:0] held key (0x00 none), key_valid make pulse, frame_err reject/timeout pulse.
// Build macro: PS2_WASD_EN (see frogger_kb_pkg) enables W/A/S/D as plain movement codes.
module ps2_keycode_rx
   import frogger_kb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] keycode,
   output logic       key_valid,
   output logic       frame_err
);

   logic [7:0] rx_byte;
   logic       byte_valid;
   logic       err;
   logic [7:0] plain_kc, ext_kc;

   kb_state_t  state_q;
   logic [7:0] keycode_q;
   logic       key_valid_q;

   ps2_frame_rx #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .SYNC_STAGES   (SYNC_STAGES)
   ) u_frame_rx (
      .Clk       (Clk),
      .Reset     (Reset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .rx_byte   (rx_byte),
      .byte_valid(byte_valid),
      .err       (err)
   );

   assign plain_kc = map_plain(rx_byte);
   assign ext_kc   = map_ext(rx_byte);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= ST_IDLE;
         keycode_q   <= KC_NONE;
         key_valid_q <= 1'b0;
      end else begin
         key_valid_q <= 1'b0;
         if (err) begin
            // A rejected frame also abandons any pending E0/F0 prefix.
            state_q <= ST_IDLE;
         end else if (byte_valid) begin
            case (state_q)
               ST_IDLE: begin
                  if (rx_byte == SC_EXT) begin
                     state_q <= ST_EXT;
                  end else if (rx_byte == SC_BRK) begin
                     state_q <= ST_BRK;
                  end else if (plain_kc != KC_NONE) begin
                     keycode_q   <= plain_kc;
                     key_valid_q <= 1'b1;
                  end
               end
               ST_EXT: begin
                  if (rx_byte == SC_BRK) begin
                     state_q <= ST_EXT_BRK;
                  end else begin
                     state_q <= ST_IDLE;
                     if (ext_kc != KC_NONE) begin
                        keycode_q   <= ext_kc;
                        key_valid_q <= 1'b1;
                     end
                  end
               end
               ST_BRK: begin
                  // Only releasing the key currently held clears the output.
                  state_q <= ST_IDLE;
                  if (plain_kc != KC_NONE && plain_kc == keycode_q) begin
                     keycode_q <= KC_NONE;
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
                  if (ext_kc != KC_NONE && ext_kc == keycode_q) begin
                     keycode_q <= KC_NONE;
                  end
               end
            endcase
         end
      end
   end

   assign keycode   = keycode_q;
   assign key_valid = key_valid_q;
   assign frame_err = err;

endmodule
